// File: rtl/mw_serial_adder_if.sv
// Handshake bundle for the multi-word serial adder: operand request side and result side.
interface mw_serial_adder_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/mw_serial_adder.sv
// Multi-word sequential adder: one WORD_W-bit ripple slice per cycle, LSB slice first,
// carry registered between slices, valid/ready on both sides.
module mw_serial_adder #(
    parameter int WORD_W = 16,
    parameter int NSLICE = 4
) (
    input  logic              clk,
    input  logic              rst,
    mw_serial_adder_if.slave  bus
);
    localparam int W     = WORD_W * NSLICE;
    localparam int IDX_W = $clog2(NSLICE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Ripple-carry slice adder; returns {carry into MSB, carry out, sum}.
    function automatic logic [WORD_W+1:0] ripple_add(
        input logic [WORD_W-1:0] x,
        input logic [WORD_W-1:0] y,
        input logic              ci
    );
        logic [WORD_W:0]   c;
        logic [WORD_W-1:0] s;
        c[0] = ci;
        for (int i = 0; i < WORD_W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
        return {c[WORD_W-1], c[WORD_W], s};
    endfunction

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WORD_W+1:0]  slice_s;
    int                 base_s;

    // Next-state and datapath: one slice of the wide sum per RUN cycle.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        base_s      = int'(idx_q) * WORD_W;
        slice_s     = ripple_add(a_q[base_s +: WORD_W], b_q[base_s +: WORD_W], carry_q);
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.a;
                    b_d        = bus.b;
                    carry_d    = bus.cin;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_RUN;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_RUN: begin
                sum_d[base_s +: WORD_W] = slice_s[WORD_W-1:0];
                carry_d                 = slice_s[WORD_W];
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    // Final slice: its carries decide the unsigned and signed flags.
                    cout_d      = slice_s[WORD_W];
                    ovf_d       = slice_s[WORD_W+1] ^ slice_s[WORD_W];
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset that discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mw_serial_adder.sv
// Self-checking bench for mw_serial_adder (W=64, WORD_W=16, NSLICE=4).
module tb_mw_serial_adder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mw_serial_adder_if #(.W(64)) bus();

    mw_serial_adder #(.WORD_W(16), .NSLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    // Reference: plain wide arithmetic; returns {ovf, cout, sum}.
    function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [64:0] full;
        logic        ov;
        full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        ov   = (a[63] == b[63]) && (full[63] != a[63]);
        return {ov, full};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic [63:0] es, input logic eco, input logic eov, input string tag);
        int n;
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.cin      = ~cin;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd5);
        check({tag, " sum"}, bus.sum, es);
        check({tag, " cout"}, 64'(bus.cout), 64'(eco));
        check({tag, " ovf"}, 64'(bus.ovf), 64'(eov));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, " post out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " post in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    function automatic logic [63:0] rand64();
        logic [63:0] v;
        for (int h = 0; h < 2; h++) begin
            case ($urandom_range(0, 5))
                0:       v[h*32 +: 32] = 32'h0000_0000;
                1:       v[h*32 +: 32] = 32'hFFFF_FFFF;
                2:       v[h*32 +: 32] = 32'h7FFF_FFFF;
                default: v[h*32 +: 32] = $urandom;
            endcase
        end
        return v;
    endfunction

    initial begin
        vec_t          vecs[7];
        logic [65:0]   r;
        logic [65:0]   r2;
        logic [63:0]   a2;
        logic [63:0]   b2;
        logic [65:0]   expq[$];
        logic [65:0]   e;
        logic          pend;
        logic [63:0]   pa;
        logic [63:0]   pb;
        logic          pc;
        logic          acc;
        logic          ohs;
        int            issued;
        int            received;
        int            cyc;
        int            n;

        checks = 0;
        errors = 0;
        vecs[0] = '{64'h0000_0000_0000_0005, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[4] = '{64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 64'd0;
        bus.b         = 64'd0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset sum", bus.sum, 64'd0);
        check("reset cout", 64'(bus.cout), 64'd0);
        check("reset ovf", 64'(bus.ovf), 64'd0);
        rst = 1'b0;
        tick();
        check("post-reset in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov, $sformatf("vec%0d", i));

        // Backpressure: result must hold while a new request waits.
        r = ref_add(64'h1111_2222_3333_4444, 64'hEEEE_DDDD_CCCC_BBBC, 1'b1);
        bus.a = 64'h1111_2222_3333_4444; bus.b = 64'hEEEE_DDDD_CCCC_BBBC; bus.cin = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        a2 = 64'h8000_0000_0000_0001; b2 = 64'hFFFF_0000_FFFF_0000;
        r2 = ref_add(a2, b2, 1'b0);
        bus.a = a2; bus.b = b2; bus.cin = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp latency", 64'(n), 64'd5);
        for (int k = 0; k < 10; k++) begin
            check("bp in_ready", 64'(bus.in_ready), 64'd0);
            check("bp out_valid", 64'(bus.out_valid), 64'd1);
            check("bp sum", bus.sum, r[63:0]);
            check("bp cout/ovf", 64'({bus.ovf, bus.cout}), 64'(r[65:64]));
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp handshake in_ready", 64'(bus.in_ready), 64'd1);
        check("bp handshake out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        check("bp accept in_ready", 64'(bus.in_ready), 64'd0);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp2 latency", 64'(n), 64'd5);
        check("bp2 sum", bus.sum, r2[63:0]);
        check("bp2 cout/ovf", 64'({bus.ovf, bus.cout}), 64'(r2[65:64]));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset during the second RUN cycle discards the operation.
        bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'h1; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid out_valid", 64'(bus.out_valid), 64'd0);
        check("rst mid in_ready", 64'(bus.in_ready), 64'd1);
        check("rst mid sum", bus.sum, 64'd0);
        check("rst mid cout", 64'(bus.cout), 64'd0);
        run_op(64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0, "after rst");

        // Random traffic with stalls on both sides, scoreboarded in order.
        pend = 1'b0; pa = 64'd0; pb = 64'd0; pc = 1'b0;
        issued = 0; received = 0; cyc = 0;
        while (received < 1000 && cyc < 40000) begin
            if (!pend && issued < 1000 && $urandom_range(0, 1) == 1) begin
                pend = 1'b1;
                pa = rand64();
                pb = rand64();
                pc = 1'($urandom_range(0, 1));
            end
            bus.in_valid  = pend;
            bus.a         = pend ? pa : rand64();
            bus.b         = pend ? pb : rand64();
            bus.cin       = pend ? pc : 1'b0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            acc = bus.in_valid && bus.in_ready;
            ohs = bus.out_valid && bus.out_ready;
            if (ohs) begin
                if (expq.size() == 0) begin
                    check("rnd spurious result", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    check("rnd sum", bus.sum, e[63:0]);
                    check("rnd cout/ovf", 64'({bus.ovf, bus.cout}), 64'(e[65:64]));
                end
                received++;
            end
            if (acc) begin
                expq.push_back(ref_add(pa, pb, pc));
                pend = 1'b0;
                issued++;
            end
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("rnd results received", 64'(received), 64'd1000);
        check("rnd ops issued", 64'(issued), 64'd1000);
        check("rnd queue empty", 64'(expq.size()), 64'd0);
        tick();
        check("rnd final out_valid", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
